// File: rtl/load_extend_ctrl.sv
// ---------------------------------------------------------------------------
// load_extend_ctrl
//   Sequences byte / halfword / word loads. It drives the memory read
//   handshake (MFA/MOC) and aligns the returned word by byte lane. For signed
//   sub-word loads it pulses the external registered signExtension unit and
//   writes its result back. Unsigned loads bypass that unit and are
//   zero-extended here. Word loads pass through unchanged.
//
// Configuration macro:
//   LDX_TIMEOUT_EN - when defined, RD gives up after MOC_LIMIT cycles without
//                    MOC and reports err. When undefined, RD waits for MOC
//                    indefinitely.
//
// Ports:
//   CLK, CLR    clock (rising edge), asynchronous active-low reset
//   start       load request, sampled in IDLE only
//   addr_lo     address bits [1:0], captured with start
//   dataSize    00 byte, 01 halfword, 10 word, 11 reserved
//   signed_ld   1 = sign-extend via signExtension, 0 = zero-extend
//   MOC         memory operation complete
//   mem_data    read data, valid while MOC = 1
//   MFA         memory read request (high throughout RD)
//   ext_D       lane-aligned data to signExtension
//   ext_size    captured dataSize to signExtension
//   ext_E       signExtension enable, one-cycle pulse
//   ext_Q       signExtension result, valid the cycle after ext_E
//   rf_we       register-file write enable, one-cycle pulse
//   rf_data     write-back data, valid while rf_we = 1
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse (with rf_we or err)
//   err         one-cycle pulse for misaligned / reserved size (or timeout)
// ---------------------------------------------------------------------------
module load_extend_ctrl #(
  parameter int DATA_W    = 32,
  parameter int MOC_LIMIT = 15
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        dataSize,
  input  logic              signed_ld,
  input  logic              MOC,
  input  logic [DATA_W-1:0] mem_data,
  output logic              MFA,
  output logic [DATA_W-1:0] ext_D,
  output logic [1:0]        ext_size,
  output logic              ext_E,
  input  logic [DATA_W-1:0] ext_Q,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // The lane-alignment shift and the masks assume a 32-bit datapath.
  if (DATA_W != 32 || MOC_LIMIT < 1) begin : gParamCheck
    $error("load_extend_ctrl: DATA_W must be 32 and MOC_LIMIT must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EXT  = 3'd2,
    EXW  = 3'd3,
    WB   = 3'd4,
    FLT  = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state, nextState;
  logic [1:0]        addrLo;
  logic              signedLd;
  logic              reqFault;
  logic              timeoutHit;
  logic [DATA_W-1:0] alignedData;
  logic [DATA_W-1:0] zeroExtData;

  // A request faults on the reserved size or when it is not naturally aligned.
  always_comb begin
    reqFault = 1'b0;
    unique case (dataSize)
      SZ_BYTE: reqFault = 1'b0;
      SZ_HALF: reqFault = addr_lo[0];
      SZ_WORD: reqFault = (addr_lo != 2'b00);
      default: reqFault = 1'b1;
    endcase
  end

  // Move the addressed lane down to bit 0, then clear the bits above the access size.
  assign alignedData = mem_data >> {addrLo, 3'b000};

  always_comb begin
    zeroExtData = alignedData;
    unique case (ext_size)
      SZ_BYTE: zeroExtData = DATA_W'(alignedData[7:0]);
      SZ_HALF: zeroExtData = DATA_W'(alignedData[15:0]);
      default: zeroExtData = alignedData;
    endcase
  end

`ifdef LDX_TIMEOUT_EN
  localparam int CNT_W = (MOC_LIMIT < 16) ? 4 : $clog2(MOC_LIMIT + 1);
  logic [CNT_W-1:0] mocWaitCnt;

  // RD is only entered from IDLE, so clearing in IDLE clears on every RD entry.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                     mocWaitCnt <= '0;
    else if (state == IDLE)       mocWaitCnt <= '0;
    else if (state == RD && !MOC) mocWaitCnt <= mocWaitCnt + 1'b1;
  end

  // Becomes true during the MOC_LIMIT-th RD cycle without MOC.
  assign timeoutHit = (state == RD) && (mocWaitCnt == CNT_W'(MOC_LIMIT - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of the order of the blocks.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= IDLE;
    else      state <= nextState;
  end

  // NOTE: every output and nextState receives a default before the case
  // statement, so no path through the block can leave a latch behind.
  always_comb begin
    nextState = state;
    MFA       = 1'b0;
    ext_E     = 1'b0;
    rf_we     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: if (start) nextState = reqFault ? FLT : RD;
      RD: begin
        MFA = 1'b1;
        if (MOC)             nextState = (signedLd && ext_size != SZ_WORD) ? EXT : WB;
        else if (timeoutHit) nextState = FLT;
      end
      EXT: begin
        ext_E     = 1'b1;
        nextState = EXW;
      end
      EXW: nextState = WB;
      WB: begin
        rf_we     = 1'b1;
        done      = 1'b1;
        nextState = IDLE;
      end
      FLT: begin
        err       = 1'b1;
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: these are few, plain data registers, so they get the asynchronous
  // reset as well. A reset must leave ext_D and rf_data at zero.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      addrLo   <= '0;
      ext_size <= '0;
      signedLd <= 1'b0;
      ext_D    <= '0;
      rf_data  <= '0;
    end else begin
      if (state == IDLE && start) begin
        addrLo   <= addr_lo;
        ext_size <= dataSize;
        signedLd <= signed_ld;
      end
      // For a signed sub-word load, the zero-extended value written here is
      // replaced by ext_Q in EXW before WB.
      if (state == RD && MOC) begin
        ext_D   <= alignedData;
        rf_data <= zeroExtData;
      end
      if (state == EXW) rf_data <= ext_Q;
    end
  end

endmodule

// File: tb/tb_load_extend_ctrl.sv
// ---------------------------------------------------------------------------
// tb_load_extend_ctrl
//   Directed and randomized loads against a behavioural reference model. The
//   model applies natural-alignment fault rules and computes the loaded value
//   with plain arithmetic (shift, modulo, two's-complement wrap). The bench
//   also models the external registered signExtension unit that drives ext_Q.
// ---------------------------------------------------------------------------
module tb_load_extend_ctrl;

  localparam int MOC_LIMIT = 15;

  logic        CLK;
  logic        CLR;
  logic        start;
  logic [1:0]  addr_lo;
  logic [1:0]  dataSize;
  logic        signed_ld;
  logic        MOC;
  logic [31:0] mem_data;
  logic        MFA;
  logic [31:0] ext_D;
  logic [1:0]  ext_size;
  logic        ext_E;
  logic [31:0] ext_Q;
  logic        rf_we;
  logic [31:0] rf_data;
  logic        busy;
  logic        done;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  load_extend_ctrl #(.DATA_W(32), .MOC_LIMIT(MOC_LIMIT)) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .start    (start),
    .addr_lo  (addr_lo),
    .dataSize (dataSize),
    .signed_ld(signed_ld),
    .MOC      (MOC),
    .mem_data (mem_data),
    .MFA      (MFA),
    .ext_D    (ext_D),
    .ext_size (ext_size),
    .ext_E    (ext_E),
    .ext_Q    (ext_Q),
    .rf_we    (rf_we),
    .rf_data  (rf_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model of the external signExtension unit. It registers its result one
  // cycle after the enable.
  always @(posedge CLK or negedge CLR) begin
    if (!CLR) ext_Q <= '0;
    else if (ext_E) begin
      case (ext_size)
        2'b00:   ext_Q <= {{24{ext_D[7]}}, ext_D[7:0]};
        2'b01:   ext_Q <= {{16{ext_D[15]}}, ext_D[15:0]};
        default: ext_Q <= ext_D;
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic bit isFault(input logic [1:0] sz, input logic [1:0] a);
    int bytes;
    if (sz == 2'b11) return 1'b1;
    bytes = 1 << sz;
    return (int'(a) % bytes) != 0;
  endfunction

  function automatic logic [31:0] expAligned(input logic [1:0] a, input logic [31:0] data);
    return data >> (8 * int'(a));
  endfunction

  function automatic logic [31:0] expResult(input logic [1:0] sz, input logic [1:0] a,
                                            input logic sgn, input logic [31:0] data);
    longint v;
    longint m;
    int     bits;
    bits = 8 << sz;
    m    = longint'(1) << bits;
    v    = longint'(expAligned(a, data)) % m;
    if (sgn && bits < 32 && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete load, starting in IDLE and returning to IDLE. Cycle-by-cycle
  // expectations follow the state walk: RD for waitCyc+1 cycles, then EXT and
  // EXW for signed sub-word loads, then WB.
  task automatic runLoad(input string tag, input logic [1:0] sz, input logic [1:0] a,
                         input logic sgn, input logic [31:0] data, input int waitCyc);
    bit          flt;
    bit          useExt;
    logic [31:0] aligned;
    flt     = isFault(sz, a);
    useExt  = sgn && (sz < 2'b10);
    aligned = expAligned(a, data);

    start = 1'b1; dataSize = sz; addr_lo = a; signed_ld = sgn; MOC = 1'b0;
    check({tag, "/idle_busy"}, 32'(busy), 32'd0);
    tick();
    start = 1'b0;

    if (flt) begin
      check({tag, "/flt_err"},  32'(err),   32'd1);
      check({tag, "/flt_done"}, 32'(done),  32'd1);
      check({tag, "/flt_mfa"},  32'(MFA),   32'd0);
      check({tag, "/flt_we"},   32'(rf_we), 32'd0);
      tick();
      check({tag, "/flt_idle"}, {29'd0, busy, done, err}, 32'd0);
      return;
    end

    for (int w = 0; w < waitCyc; w++) begin
      // Requests and field changes while busy must be ignored.
      start     = 1'($urandom_range(0, 1));
      dataSize  = 2'($urandom);
      addr_lo   = 2'($urandom);
      signed_ld = 1'($urandom);
      check({tag, "/rd_mfa"},  32'(MFA),  32'd1);
      check({tag, "/rd_done"}, 32'(done), 32'd0);
      tick();
    end

    start = 1'b0; MOC = 1'b1; mem_data = data;
    check({tag, "/moc_mfa"}, 32'(MFA), 32'd1);
    tick();
    MOC = 1'($urandom_range(0, 1));
    mem_data = $urandom;
    check({tag, "/mfa_drop"}, 32'(MFA),      32'd0);
    check({tag, "/ext_D"},    ext_D,         aligned);
    check({tag, "/ext_size"}, 32'(ext_size), 32'(sz));

    if (useExt) begin
      check({tag, "/ext_E"},   32'(ext_E), 32'd1);
      check({tag, "/ext_we"},  32'(rf_we), 32'd0);
      tick();
      check({tag, "/exw_E"},   32'(ext_E), 32'd0);
      check({tag, "/exw_D"},   ext_D,      aligned);
      check({tag, "/exw_done"}, 32'(done), 32'd0);
      tick();
    end else begin
      check({tag, "/no_ext_E"}, 32'(ext_E), 32'd0);
    end

    check({tag, "/wb_we"},   32'(rf_we), 32'd1);
    check({tag, "/wb_done"}, 32'(done),  32'd1);
    check({tag, "/wb_err"},  32'(err),   32'd0);
    check({tag, "/rf_data"}, rf_data,    expResult(sz, a, sgn, data));
    tick();
    MOC = 1'b0;
    check({tag, "/back_idle"}, {29'd0, busy, rf_we, done}, 32'd0);
  endtask

  // Guards against a DUT that never completes a wait.
  initial begin
    #300000;
    $display("FAIL watchdog: observed no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    CLR = 1'b0; start = 1'b0; addr_lo = '0; dataSize = '0; signed_ld = 1'b0;
    MOC = 1'b0; mem_data = '0;
    #3;
    check("reset_ctrl", {26'd0, MFA, ext_E, rf_we, busy, done, err}, 32'd0);
    check("reset_extD", ext_D,   32'd0);
    check("reset_rf",   rf_data, 32'd0);
    @(negedge CLK);
    CLR = 1'b1;
    tick();

    // Directed cases from the design notes.
    runLoad("byte_s_a1",   2'b00, 2'b01, 1'b1, 32'h0000FF03, 2);
    runLoad("half_s_a2",   2'b01, 2'b10, 1'b1, 32'hF0E47492, 1);
    runLoad("half_u_a0",   2'b01, 2'b00, 1'b0, 32'hF0E47492, 0);
    runLoad("word_a2_flt", 2'b10, 2'b10, 1'b0, 32'h12345678, 0);
    runLoad("rsvd_flt",    2'b11, 2'b00, 1'b1, 32'h12345678, 0);
    runLoad("half_a1_flt", 2'b01, 2'b01, 1'b0, 32'h12345678, 0);
    runLoad("word_s",      2'b10, 2'b00, 1'b1, 32'h8000_0001, 1);
    runLoad("byte_u_a3",   2'b00, 2'b11, 1'b0, 32'h9A00_0000, 0);
    runLoad("byte_s_a3",   2'b00, 2'b11, 1'b1, 32'h8000_0000, 3);
    runLoad("half_s_pos",  2'b01, 2'b10, 1'b1, 32'h7FFF_FFFF, 0);

    // Mid-RD reset: outputs clear at once and no write-back follows.
    start = 1'b1; dataSize = 2'b00; addr_lo = 2'b00; signed_ld = 1'b1;
    tick();
    start = 1'b0;
    check("rst_pre_mfa", 32'(MFA), 32'd1);
    #2 CLR = 1'b0;
    #1;
    check("rst_ctrl", {26'd0, MFA, ext_E, rf_we, busy, done, err}, 32'd0);
    check("rst_extD", ext_D,   32'd0);
    check("rst_rf",   rf_data, 32'd0);
    MOC = 1'b1; mem_data = 32'hDEADBEEF;
    @(negedge CLK);
    CLR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_after", {29'd0, MFA, rf_we, busy}, 32'd0);
    end
    MOC = 1'b0;

    // Random back-to-back loads, including faulting combinations.
    for (int n = 0; n < 60; n++) begin
      runLoad("rand", 2'($urandom_range(0, 3)), 2'($urandom), 1'($urandom),
              $urandom, $urandom_range(0, 3));
    end

    // Long MOC stall.
    start = 1'b1; dataSize = 2'b10; addr_lo = 2'b00; signed_ld = 1'b0;
    tick();
    start = 1'b0;
`ifdef LDX_TIMEOUT_EN
    for (int i = 1; i <= MOC_LIMIT; i++) begin
      check("tmo_wait_mfa", 32'(MFA), 32'd1);
      check("tmo_wait_err", 32'(err), 32'd0);
      tick();
    end
    check("tmo_err",  32'(err),   32'd1);
    check("tmo_done", 32'(done),  32'd1);
    check("tmo_mfa",  32'(MFA),   32'd0);
    check("tmo_we",   32'(rf_we), 32'd0);
    tick();
    check("tmo_idle", 32'(busy), 32'd0);
`else
    for (int i = 0; i < 3 * MOC_LIMIT; i++) begin
      check("stall_busy", {30'd0, busy, MFA}, 32'd3);
      tick();
    end
    MOC = 1'b1; mem_data = 32'hCAFE_F00D;
    tick();
    MOC = 1'b0;
    check("stall_we",   32'(rf_we), 32'd1);
    check("stall_data", rf_data,    32'hCAFE_F00D);
    tick();
    check("stall_idle", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
